// File: rtl/lcd_pkg.sv
// Shared definitions for the LCD timing and test-pattern generator.
// Contents:
//   MODE_*      pattern select codes (codes 5-7 behave as MODE_SOLID)
//   bar_color   3-bit {R,G,B} on/off colour for each of the 8 colour bars
//   lvds_pack   21-bit 7:1 LVDS lane packing of a 6-bit-per-channel pixel and syncs
package lcd_pkg;

  localparam logic [2:0] MODE_SOLID = 3'd0;
  localparam logic [2:0] MODE_BARS  = 3'd1;
  localparam logic [2:0] MODE_XOR   = 3'd2;
  localparam logic [2:0] MODE_BOX   = 3'd3;
  localparam logic [2:0] MODE_EXT   = 3'd4;

  // Bars left to right: white, yellow, cyan, green, magenta, red, blue, black.
  function automatic logic [2:0] bar_color(input logic [2:0] idx);
    logic [2:0] c;
    case (idx)
      3'd0:    c = 3'b111;
      3'd1:    c = 3'b110;
      3'd2:    c = 3'b011;
      3'd3:    c = 3'b010;
      3'd4:    c = 3'b101;
      3'd5:    c = 3'b100;
      3'd6:    c = 3'b001;
      default: c = 3'b000;
    endcase
    return c;
  endfunction

  // Lane order: [20:14]={B2..B5,HS,VS,DE}, [13:7]={G1..G5,B0,B1}, [6:0]={R0..R5,G0}.
  function automatic logic [20:0] lvds_pack(input logic [5:0] r, input logic [5:0] g,
                                            input logic [5:0] b, input logic hs,
                                            input logic vs, input logic de);
    return {b[2], b[3], b[4], b[5], hs, vs, de,
            g[1], g[2], g[3], g[4], g[5], b[0], b[1],
            r[0], r[1], r[2], r[3], r[4], r[5], g[0]};
  endfunction

endpackage

// File: rtl/lcd_pattern_gen.sv
// Combinational pixel function of position, pattern mode, scroll phase and colours.
// Ports:
//   x, y       current pixel position (h/v counters)
//   mode       active pattern mode
//   phase      scroll phase for the XOR and BOX patterns
//   solid_rgb  {R,G,B} solid colour / box border colour
//   ext_rgb    {R,G,B} external pixel for MODE_EXT
//   rgb        {R,G,B} resulting pixel (not masked by DE here)
module lcd_pattern_gen
  import lcd_pkg::*;
#(
  parameter int unsigned H_ACTIVE = 1366,
  parameter int unsigned V_ACTIVE = 768,
  parameter int unsigned COLOR_W  = 6
) (
  input  logic [10:0]          x,
  input  logic [10:0]          y,
  input  logic [2:0]           mode,
  input  logic [COLOR_W-1:0]   phase,
  input  logic [3*COLOR_W-1:0] solid_rgb,
  input  logic [3*COLOR_W-1:0] ext_rgb,
  output logic [3*COLOR_W-1:0] rgb
);

  // Centre rectangle is half the active area in each direction, centred.
  localparam int BoxX0  = int'(H_ACTIVE / 4);
  localparam int BoxX1  = BoxX0 + int'(H_ACTIVE / 2);
  localparam int BoxY0  = int'(V_ACTIVE / 4);
  localparam int BoxY1  = BoxY0 + int'(V_ACTIVE / 2);
  localparam int Border = 3;

  int xi, yi, bar_i;
  logic [2:0] bar_idx, bar_rgb;
  logic [5:0] ph6, sx, sy, s;
  logic [3*COLOR_W-1:0] xor_rgb;
  logic in_hole, in_frame;

  always_comb begin
    xi = int'(x);
    yi = int'(y);

    bar_i   = (xi * 8) / int'(H_ACTIVE);
    bar_idx = (bar_i > 7) ? 3'd7 : 3'(bar_i);
    bar_rgb = bar_color(bar_idx);

    ph6 = 6'(phase);
    sx  = x[5:0] + ph6;
    sy  = y[5:0] + ph6;
    s   = sx ^ sy;
    xor_rgb = {COLOR_W'({s, 1'b0}), COLOR_W'({s, 2'b00}),
               COLOR_W'({2'b00, s} + {1'b0, s, 1'b0})};

    in_hole  = (xi >= BoxX0) && (xi < BoxX1) && (yi >= BoxY0) && (yi < BoxY1);
    in_frame = (xi >= BoxX0 - Border) && (xi < BoxX1 + Border) &&
               (yi >= BoxY0 - Border) && (yi < BoxY1 + Border);

    rgb = solid_rgb;
    case (mode)
      MODE_BARS: rgb = {{COLOR_W{bar_rgb[2]}}, {COLOR_W{bar_rgb[1]}}, {COLOR_W{bar_rgb[0]}}};
      MODE_XOR:  rgb = xor_rgb;
      MODE_BOX: begin
        if (in_hole) begin
          rgb = '0;
        end else if (in_frame) begin
          rgb = solid_rgb;
        end else begin
          rgb = xor_rgb;
        end
      end
      MODE_EXT:  rgb = ext_rgb;
      default:   rgb = solid_rgb;
    endcase
  end

endmodule

// File: rtl/lcd_timing_pattern_gen.sv
// LCD video timing and test-pattern generator feeding a 7:1 LVDS serialiser.
// Ports:
//   clk, rst         pixel clock, synchronous active-high reset
//   en               run enable; low parks counters at 0 with blanked outputs
//   mode_i           pattern select, latched at frame start
//   solid_rgb_i      solid / border colour
//   scroll_step_i    per-frame phase increment
//   ext_rgb_i        external pixel for the current position
//   pos_x_o/pos_y_o  current h/v counters
//   de_o/hsync_o/vsync_o/rgb_o  registered timing and pixel (latency 1)
//   video_o          LVDS-packed {rgb_o, hsync_o, vsync_o, de_o}
//   frame_start_o    1-cycle pulse aligned with the first active pixel
//   frame_cnt_o      frames started since reset
module lcd_timing_pattern_gen
  import lcd_pkg::*;
#(
  parameter int unsigned H_ACTIVE     = 1366,
  parameter int unsigned H_FP         = 48,
  parameter int unsigned H_SYNC       = 32,
  parameter int unsigned H_BP         = 89,
  parameter int unsigned V_ACTIVE     = 768,
  parameter int unsigned V_FP         = 3,
  parameter int unsigned V_SYNC       = 5,
  parameter int unsigned V_BP         = 4,
  parameter int unsigned COLOR_W      = 6,
  parameter bit          SYNC_ACT_LOW = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic [2:0]           mode_i,
  input  logic [3*COLOR_W-1:0] solid_rgb_i,
  input  logic [COLOR_W-1:0]   scroll_step_i,
  input  logic [3*COLOR_W-1:0] ext_rgb_i,
  output logic [10:0]          pos_x_o,
  output logic [10:0]          pos_y_o,
  output logic                 de_o,
  output logic                 hsync_o,
  output logic                 vsync_o,
  output logic [3*COLOR_W-1:0] rgb_o,
  output logic [20:0]          video_o,
  output logic                 frame_start_o,
  output logic [15:0]          frame_cnt_o
);

  localparam logic [10:0] HLast    = 11'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [10:0] HAct     = 11'(H_ACTIVE);
  localparam logic [10:0] HSyncBeg = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HSyncEnd = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] VLast    = 11'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [10:0] VAct     = 11'(V_ACTIVE);
  localparam logic [10:0] VSyncBeg = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] VSyncEnd = 11'(V_ACTIVE + V_FP + V_SYNC);

  logic [10:0]          h_q, v_q;
  logic [2:0]           mode_q, mode_eff;
  logic [COLOR_W-1:0]   phase_q, phase_eff;
  logic [15:0]          frame_cnt_q;
  logic                 de_q, hs_q, vs_q, fs_q;
  logic [3*COLOR_W-1:0] rgb_q, pix;
  logic                 frame_start, de_d, hs_act, vs_act;

  // The frame-start cycle already renders the new frame's first pixel, so it
  // must see the freshly latched mode and advanced phase.
  always_comb begin
    frame_start = en && (h_q == 11'd0) && (v_q == 11'd0);
    mode_eff    = frame_start ? mode_i : mode_q;
    phase_eff   = frame_start ? phase_q + scroll_step_i : phase_q;
    de_d        = (h_q < HAct) && (v_q < VAct);
    hs_act      = (h_q >= HSyncBeg) && (h_q < HSyncEnd);
    vs_act      = (v_q >= VSyncBeg) && (v_q < VSyncEnd);
  end

  lcd_pattern_gen #(
    .H_ACTIVE (H_ACTIVE),
    .V_ACTIVE (V_ACTIVE),
    .COLOR_W  (COLOR_W)
  ) u_pattern (
    .x         (h_q),
    .y         (v_q),
    .mode      (mode_eff),
    .phase     (phase_eff),
    .solid_rgb (solid_rgb_i),
    .ext_rgb   (ext_rgb_i),
    .rgb       (pix)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      h_q         <= 11'd0;
      v_q         <= 11'd0;
      mode_q      <= MODE_SOLID;
      phase_q     <= '0;
      frame_cnt_q <= 16'd0;
      de_q        <= 1'b0;
      hs_q        <= SYNC_ACT_LOW;
      vs_q        <= SYNC_ACT_LOW;
      fs_q        <= 1'b0;
      rgb_q       <= '0;
    end else if (!en) begin
      // Mode, phase and frame count are deliberately held across en low.
      h_q   <= 11'd0;
      v_q   <= 11'd0;
      de_q  <= 1'b0;
      hs_q  <= SYNC_ACT_LOW;
      vs_q  <= SYNC_ACT_LOW;
      fs_q  <= 1'b0;
      rgb_q <= '0;
    end else begin
      if (h_q == HLast) begin
        h_q <= 11'd0;
        v_q <= (v_q == VLast) ? 11'd0 : v_q + 11'd1;
      end else begin
        h_q <= h_q + 11'd1;
      end
      if (frame_start) begin
        mode_q      <= mode_i;
        phase_q     <= phase_eff;
        frame_cnt_q <= frame_cnt_q + 16'd1;
      end
      de_q  <= de_d;
      hs_q  <= hs_act ^ SYNC_ACT_LOW;
      vs_q  <= vs_act ^ SYNC_ACT_LOW;
      fs_q  <= frame_start;
      rgb_q <= de_d ? pix : '0;
    end
  end

  assign pos_x_o       = h_q;
  assign pos_y_o       = v_q;
  assign de_o          = de_q;
  assign hsync_o       = hs_q;
  assign vsync_o       = vs_q;
  assign rgb_o         = rgb_q;
  assign frame_start_o = fs_q;
  assign frame_cnt_o   = frame_cnt_q;

  // Only the 6-bit-per-channel format has a defined lane mapping.
  if (COLOR_W == 6) begin : g_pack
    assign video_o = lvds_pack(rgb_q[17:12], rgb_q[11:6], rgb_q[5:0], hs_q, vs_q, de_q);
  end else begin : g_nopack
    assign video_o = '0;
  end

endmodule
